// File: rtl/disp_pkg.sv
// Shared constants, source indices and FSM state type for the display message arbiter.
package disp_pkg;
    localparam logic [1:0] SRC_ERR    = 2'd0;
    localparam logic [1:0] SRC_RES    = 2'd1;
    localparam logic [1:0] SRC_PROMPT = 2'd2;
    localparam logic [1:0] SRC_BG     = 2'd3;

    localparam logic [15:0] DEF_BLANK_WORD = 16'hFFFF;
    localparam logic [15:0] WORD_GOOD      = 16'h900D;
    localparam logic [15:0] WORD_GOGO      = 16'h9090;
    localparam logic [15:0] WORD_ERR       = 16'hFEEE;
    localparam logic [15:0] WORD_LOSE      = 16'hC05E;

    typedef enum logic {ST_IDLE, ST_SHOW} disp_state_e;

    // Fixed priority: lowest index wins; SRC_BG means nothing requested.
    function automatic logic [1:0] pick_src(input logic [2:0] r);
        if (r[0])      return SRC_ERR;
        else if (r[1]) return SRC_RES;
        else if (r[2]) return SRC_PROMPT;
        else           return SRC_BG;
    endfunction
endpackage

// File: rtl/disp_tick_gen.sv
// Display tick prescaler: one-cycle tick every TICK_DIV cycles, restartable at 0.
module disp_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/display_message_arbiter.sv
// Priority arbiter holding one message on the 7-segment word for a tick-based duration.
// Optional per-message blinking is enabled by defining DISP_ARB_BLINK_EN.
module display_message_arbiter
    import disp_pkg::*;
#(
    parameter int          TICK_DIV   = 25000000,
    parameter logic [15:0] BLANK_WORD = DEF_BLANK_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [47:0] msg_flat,
    input  logic [11:0] hold_flat,
    input  logic [15:0] bg_data,
`ifdef DISP_ARB_BLINK_EN
    input  logic [2:0]  blink,
`endif
    output logic [2:0]  ack,
    output logic [15:0] seg_data,
    output logic        busy,
    output logic [1:0]  active_src
);
    disp_state_e state_q, state_d;
    logic [1:0]  src_q, src_d;
    logic [15:0] msg_q, msg_d;
    logic [15:0] seg_q, seg_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic [2:0]  ack_q, ack_d;
    logic        blink_q, blink_d;
    logic        phase_q, phase_d;
    logic [2:0]  blink_in;
    logic [2:0]  req_eff;
    logic [1:0]  win;
    logic [3:0]  hold_sel;
    logic        accept, expire, tick;

`ifdef DISP_ARB_BLINK_EN
    assign blink_in = blink;
`else
    assign blink_in = '0;
`endif

    disp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(accept),
        .tick   (tick)
    );

    // A source acked last cycle cannot be re-acked before it drops req.
    assign req_eff  = req & ~ack_q;
    assign win      = pick_src(req_eff);
    assign hold_sel = hold_flat[{win, 2'b00} +: 4];
    assign expire   = (state_q == ST_SHOW) && tick && (hold_cnt_q <= 4'd1);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        msg_d      = msg_q;
        seg_d      = seg_q;
        hold_cnt_d = hold_cnt_q;
        blink_d    = blink_q;
        phase_d    = phase_q;
        ack_d      = '0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_eff) accept = 1'b1;
                else          seg_d  = bg_data;
            end
            ST_SHOW: begin
                if ((|req_eff) && (win < src_q || expire)) begin
                    accept = 1'b1;
                end else if (expire) begin
                    state_d    = ST_IDLE;
                    src_d      = SRC_BG;
                    seg_d      = bg_data;
                    hold_cnt_d = '0;
                    blink_d    = 1'b0;
                    phase_d    = 1'b0;
                end else begin
                    if (tick) begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                        phase_d    = ~phase_q;
                    end
                    seg_d = (blink_q && phase_d) ? BLANK_WORD : msg_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d    = ST_SHOW;
            src_d      = win;
            msg_d      = msg_flat[{win, 4'b0000} +: 16];
            seg_d      = msg_flat[{win, 4'b0000} +: 16];
            hold_cnt_d = (hold_sel == 4'd0) ? 4'd1 : hold_sel;
            blink_d    = blink_in[win];
            phase_d    = 1'b0;
            ack_d[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_BG;
            msg_q      <= '0;
            seg_q      <= BLANK_WORD;
            hold_cnt_q <= '0;
            ack_q      <= '0;
            blink_q    <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            msg_q      <= msg_d;
            seg_q      <= seg_d;
            hold_cnt_q <= hold_cnt_d;
            ack_q      <= ack_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
        end
    end

    assign ack        = ack_q;
    assign seg_data   = seg_q;
    assign busy       = (state_q == ST_SHOW);
    assign active_src = src_q;
endmodule

// File: doc/display_message_arbiter.md
DISPLAY_MESSAGE_ARBITER -- requirements
Module: display_message_arbiter

Interface
REQ-001 Parameter TICK_DIV, 25000000, clock cycles per display tick (minimum 2).
REQ-002 Parameter BLANK_WORD, 16'hFFFF, word driven when nothing valid is shown.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  per-source request level; source 0 has highest priority, source 2 lowest.
REQ-006 msg_flat  input  48  message words; source i uses bits [16i+15:16i].
REQ-007 hold_flat  input  12  hold times in ticks; source i uses bits [4i+3:4i].
REQ-008 bg_data  input  16  background word shown when no message is active.
REQ-009 blink  input  3  per-source blink request; present only when DISP_ARB_BLINK_EN is defined.
REQ-010 ack  output  3  one-cycle acceptance pulse per source.
REQ-011 seg_data  output  16  registered word for the 7-segment display controller.
REQ-012 busy  output  1  high while a message is being held.
REQ-013 active_src  output  2  source being shown: 0-2, or 3 for background.

Function
REQ-014 The FSM SHALL have two states: IDLE (show background) and SHOW (hold the latched message).
REQ-015 In IDLE, seg_data SHALL register bg_data every cycle, giving one-cycle latency.
REQ-016 Accept: the highest-priority asserted req SHALL be sampled at edge t; at edge t+1 ack[i]=1 for one cycle, seg_data=msg_i, busy=1, active_src=i, state=SHOW.
REQ-017 Msg, hold and blink SHALL be latched at accept; later changes SHALL have no effect on the shown message.
REQ-018 Requesters hold req, msg and hold stable until ack; a req dropped before ack SHALL be ignored without error.
REQ-019 On accept, the tick prescaler SHALL restart at 0, so a hold of N ticks lasts exactly N*TICK_DIV cycles; hold=0 SHALL be treated as 1.
REQ-020 Preemption: a req from a strictly higher-priority source during SHOW SHALL be accepted per REQ-016 and SHALL restart the hold; the preempted message SHALL be dropped, not resumed.
REQ-021 An equal- or lower-priority req during SHOW SHALL wait, with no ack, until the hold expires.
REQ-022 At hold expiry, if any req is asserted, the highest-priority one SHALL be accepted on that same edge, with no background cycle; otherwise the FSM SHALL return to IDLE, with busy=0, active_src=3 and seg_data=bg_data.
REQ-023 ack SHALL be one-hot or zero and SHALL never be asserted in two consecutive cycles for the same request.
REQ-024 The prescaler and hold counter SHALL not wrap mid-hold; the hold counter SHALL be 4 bits, and the prescaler SHALL be $clog2(TICK_DIV) bits.

Reset
REQ-025 During reset: state=IDLE, seg_data=BLANK_WORD, ack=0, busy=0, active_src=3, counters=0, latched blink=0.
REQ-026 Reset asserted mid-SHOW SHALL abort the message immediately; the first edge after release SHALL show bg_data.

Configuration
REQ-027 With DISP_ARB_BLINK_EN defined, a message accepted with blink[i]=1 SHALL alternate each tick: msg, BLANK_WORD, msg, and so on, starting with msg.
REQ-028 Without DISP_ARB_BLINK_EN, the blink port SHALL be absent and messages SHALL be held steady.

Structure
REQ-029 Shared package disp_pkg SHALL hold: source indices SRC_ERR=0, SRC_RES=1, SRC_PROMPT=2, SRC_BG=3; the state enum; BLANK_WORD default; and word constants WORD_GOOD=16'h900D, WORD_GOGO=16'h9090, WORD_ERR=16'hFEEE, WORD_LOSE=16'hC05E.
REQ-030 The tick prescaler SHALL be a sub-module disp_tick_gen with inputs clk, reset, restart and output tick.

Verification (TICK_DIV=4)
REQ-031 Release reset with bg_data=16'h1F66 -> seg_data is FFFF during reset and 1F66 one cycle after release; active_src=3.
REQ-032 req[1] with WORD_GOOD, hold 2 -> ack[1] pulses once; seg_data=900D for exactly 8 cycles, then 1F66; busy is high for the same 8 cycles.
REQ-033 Source 2 showing 9090 with hold 5; req[0] asserted with FEEE, hold 1 -> ack[0] next cycle; FEEE shown for 4 cycles; then background (9090 is not resumed).
REQ-034 req[0] and req[1] asserted together in IDLE -> only ack[0]; req[1] is acked on the FEEE expiry edge, and C05E follows with no 1F66 cycle between.
REQ-035 Reset pulsed mid-hold -> outputs reach reset values on the next edge; no ack is issued for req held through reset until after release.
REQ-036 With DISP_ARB_BLINK_EN: hold 4, blink=1, msg C05E -> the four 4-cycle ticks show C05E, FFFF, C05E, FFFF.
